// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-step / run CPU controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } cpu_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debounce and
// a one-cycle press pulse on the debounced rising edge.
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic SYS_clk,
    input  logic SYS_reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] stable_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle;
    // press is raised in the same update so it lines up with the new level.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync2;
                    press      <= sync2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: HALT / RUN / STEP modes driven by debounced
// buttons, divided_clk ticks and a CPU halt request.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             divided_clk,
    input  logic             btn_step,
    input  logic             btn_mode,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             run_mode,
    output logic [CNT_W-1:0] step_count
);

    logic       div_s1, div_s2, div_s3;
    logic       tick;
    logic       step_level, step_press;
    logic       mode_level, mode_press;
    cpu_state_e state, state_nxt;
    logic       cpu_en_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .btn       (btn_step),
        .level     (step_level),
        .press     (step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .btn       (btn_mode),
        .level     (mode_level),
        .press     (mode_press)
    );

    // div_s3 only remembers the previous synchronized sample for edge detect.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
            div_s3 <= 1'b0;
        end else begin
            div_s1 <= divided_clk;
            div_s2 <= div_s1;
            div_s3 <= div_s2;
        end
    end

    assign tick = div_s2 & ~div_s3;

    always_comb begin
        state_nxt  = state;
        cpu_en_nxt = 1'b0;
        case (state)
            ST_HALT: begin
                if (mode_press) begin
                    state_nxt = ST_RUN;
                end else if (step_press) begin
                    state_nxt  = ST_STEP;
                    cpu_en_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop requests beat a coincident tick.
                if (halt_req || mode_press) begin
                    state_nxt = ST_HALT;
                end else if (tick) begin
                    cpu_en_nxt = 1'b1;
                end
            end
            ST_STEP: state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state      <= ST_HALT;
            cpu_en     <= 1'b0;
            run_mode   <= 1'b0;
            step_count <= '0;
        end else begin
            state    <= state_nxt;
            cpu_en   <= cpu_en_nxt;
            run_mode <= (state_nxt == ST_RUN);
            if (cpu_en)
                step_count <= step_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomized scoreboard bench for cpu_step_ctrl with a transaction-level model.
module tb_cpu_step_ctrl;

    localparam int DB = 4;
    localparam int CW = 4;

    typedef struct {
        logic [CW-1:0] cnt;
        bit            is_tick;
        int            rise;
    } exp_t;

    logic          SYS_clk = 1'b0;
    logic          SYS_reset = 1'b1;
    logic          divided_clk = 1'b0;
    logic          btn_step = 1'b0;
    logic          btn_mode = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_en;
    logic          run_mode;
    logic [CW-1:0] step_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            m_run = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    exp_t          q[$];

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .divided_clk (divided_clk),
        .btn_step    (btn_step),
        .btn_mode    (btn_mode),
        .halt_req    (halt_req),
        .cpu_en      (cpu_en),
        .run_mode    (run_mode),
        .step_count  (step_count)
    );

    always #5 SYS_clk = ~SYS_clk;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge SYS_clk);
    endtask

    task automatic set_btn(input bit is_mode, input logic v);
        if (is_mode) btn_mode = v;
        else         btn_step = v;
    endtask

    // Expected effect of a press is booked before the press so the monitor
    // already holds it when the pulse appears.
    task automatic press(input bit is_mode, input int bounces);
        if (is_mode) begin
            m_run = !m_run;
        end else if (!m_run) begin
            m_cnt = m_cnt + 1'b1;
            q.push_back('{cnt: m_cnt, is_tick: 1'b0, rise: 0});
        end
        @(negedge SYS_clk);
        for (int i = 0; i < bounces; i++) begin
            set_btn(is_mode, 1'b1); wait_cyc(1);
            set_btn(is_mode, 1'b0); wait_cyc(1);
        end
        set_btn(is_mode, 1'b1); wait_cyc(10);
        set_btn(is_mode, 1'b0); wait_cyc(10);
    endtask

    task automatic tick();
        @(negedge SYS_clk);
        divided_clk = 1'b1;
        if (m_run) begin
            m_cnt = m_cnt + 1'b1;
            q.push_back('{cnt: m_cnt, is_tick: 1'b1, rise: cyc});
        end
        wait_cyc(8);
        divided_clk = 1'b0;
        wait_cyc(8);
    endtask

    task automatic halt_pulse();
        @(negedge SYS_clk);
        halt_req = 1'b1;
        wait_cyc(1);
        halt_req = 1'b0;
        m_run = 1'b0;
        wait_cyc(3);
    endtask

    task automatic settle(input string tag);
        wait_cyc(5);
        chk({tag, "_pending"}, q.size(), 0);
        chk({tag, "_run_mode"}, int'(run_mode), int'(m_run));
        chk({tag, "_step_count"}, int'(step_count), int'(m_cnt));
    endtask

    task automatic do_reset();
        @(negedge SYS_clk);
        SYS_reset = 1'b1;
        wait_cyc(3);
        q.delete();
        m_run = 1'b0;
        m_cnt = '0;
        SYS_reset = 1'b0;
        wait_cyc(2);
    endtask

    // Monitor: every cpu_en pulse must match the oldest booked expectation.
    initial begin
        bit            prev = 1'b0;
        bit            pend = 1'b0;
        logic [CW-1:0] pv = '0;
        exp_t          e;
        forever begin
            @(negedge SYS_clk);
            if (SYS_reset) begin
                prev = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("step_count_after_pulse", int'(step_count), int'(pv));
                    pend = 1'b0;
                end
                if (cpu_en) begin
                    chk("cpu_en_back_to_back", int'(prev), 0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cpu_en: got pulse at cycle %0d expected none", cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.is_tick)
                            chk("tick_latency_3_or_4", int'((cyc - e.rise) >= 3 && (cyc - e.rise) <= 4), 1);
                        pv   = e.cnt;
                        pend = 1'b1;
                    end
                end
                prev = cpu_en;
            end
        end
    end

    initial begin
        #1;
        chk("reset_cpu_en", int'(cpu_en), 0);
        chk("reset_run_mode", int'(run_mode), 0);
        chk("reset_step_count", int'(step_count), 0);
        wait_cyc(3);
        SYS_reset = 1'b0;
        wait_cyc(2);

        // No pulses without a press after reset.
        tick(); tick();
        settle("idle_after_reset");

        // Enter RUN and count five ticks.
        press(1'b1, 0);
        for (int i = 0; i < 5; i++) tick();
        settle("run_five");

        // halt_req in the same cycle as the synchronized tick.
        @(negedge SYS_clk);
        divided_clk = 1'b1;
        @(posedge SYS_clk); @(posedge SYS_clk);
        #1 halt_req = 1'b1;
        @(posedge SYS_clk);
        #1 halt_req = 1'b0;
        m_run = 1'b0;
        @(negedge SYS_clk);
        chk("halt_beats_tick_run_mode", int'(run_mode), 0);
        wait_cyc(6);
        divided_clk = 1'b0;
        wait_cyc(8);
        tick(); tick();
        settle("halt_vs_tick");

        // Bouncy step press in HALT: 1-0-1-0 then held.
        press(1'b0, 2);
        settle("bouncy_step");

        // Simultaneous mode and step presses in HALT.
        @(negedge SYS_clk);
        btn_mode = 1'b1; btn_step = 1'b1;
        m_run = 1'b1;
        wait_cyc(10);
        btn_mode = 1'b0; btn_step = 1'b0;
        wait_cyc(10);
        settle("dual_press");
        tick();
        press(1'b0, 0);
        settle("step_in_run_ignored");

        // Reset between divided_clk rise and the expected pulse.
        @(negedge SYS_clk);
        divided_clk = 1'b1;
        @(posedge SYS_clk); @(posedge SYS_clk);
        #1 SYS_reset = 1'b1;
        #1;
        chk("midrun_reset_cpu_en", int'(cpu_en), 0);
        chk("midrun_reset_run_mode", int'(run_mode), 0);
        chk("midrun_reset_step_count", int'(step_count), 0);
        q.delete();
        m_run = 1'b0;
        m_cnt = '0;
        wait_cyc(2);
        SYS_reset = 1'b0;
        wait_cyc(6);
        divided_clk = 1'b0;
        wait_cyc(8);
        tick(); tick();
        settle("after_midrun_reset");

        // 17 steps from zero wrap a 4-bit counter to 1.
        do_reset();
        for (int i = 0; i < 17; i++) press(1'b0, 0);
        settle("wrap");
        chk("wrap_value", int'(step_count), 1);

        // Randomized action mix.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 4: tick();
                1:    press(1'b1, int'($urandom_range(0, 3)));
                2:    press(1'b0, int'($urandom_range(0, 3)));
                default: halt_pulse();
            endcase
            if (i % 10 == 9) settle("random");
        end
        settle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
